burst_scheduler: RTL and testbench
==================================

BURST_SCHEDULER -- requirements
Module: burst_scheduler

Interface
REQ-001 The block SHALL have one clock, clk, and reset rst, which is asynchronous and active-high.
REQ-002 Parameter NUM_REQ, default 4: number of requesters.
REQ-003 Parameter CNT_NUM, default 15: pulses per burst; legal range 1 to 255.
REQ-004 Parameter CNT_GAP, default 30: cycles between pulses; legal range 2 to 255.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req  input  NUM_REQ  level request, one bit per requester.
REQ-008 gnt  output  NUM_REQ  one-hot grant, held for the whole burst.
REQ-009 busy  output  1  burst in progress.
REQ-010 pulse  output  1  single-cycle burst pulse.
REQ-011 done  output  NUM_REQ  one-cycle completion strobe to the granted requester.
REQ-012 abort  input  1  cancels the active burst; this port exists only with BURST_SCHED_ABORT_EN.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-014 IDLE: if any eligible req bit is high, the block SHALL move to RUN in the next cycle, T, with gnt one-hot for the winner and busy=1.
REQ-015 Arbitration SHALL be round-robin, starting the search at the index after the last granted requester; after reset the search SHALL start at requester 0.
REQ-016 A requester SHALL be eligible only if its req bit has been low for at least one cycle since its last done strobe; a per-requester re-arm flag SHALL track this.
REQ-017 RUN: the gap counter SHALL count 0 to CNT_GAP-1 and then wrap; pulse SHALL be 1 only in the cycle where the count equals CNT_GAP-1.
REQ-018 Pulse k, for k=1..CNT_NUM, SHALL occur in cycle T+k*CNT_GAP-1.
REQ-019 After pulse CNT_NUM, the block SHALL enter DONE in cycle T+CNT_NUM*CNT_GAP: busy=0, gnt=0, pulse=0, done[owner]=1.
REQ-020 DONE SHALL last exactly one cycle and then go to IDLE; the earliest next grant SHALL be at T+CNT_NUM*CNT_GAP+2.
REQ-021 Deasserting req during RUN SHALL NOT shorten the burst.
REQ-022 req changes during RUN or DONE SHALL be ignored for arbitration until IDLE.
REQ-023 The gap counter SHALL be $clog2(CNT_GAP) bits wide, and the pulse counter $clog2(CNT_NUM+1) bits wide.
REQ-024 Neither counter SHALL overflow; both SHALL clear on entry to RUN.

Reset
REQ-025 rst high SHALL immediately force gnt=0, busy=0, pulse=0, done=0, state=IDLE, both counters to 0, the RR pointer to requester 0, and all requesters to eligible.
REQ-026 A reset in the middle of a burst SHALL abandon the burst with no done strobe.

Configuration
REQ-027 With BURST_SCHED_ABORT_EN defined, abort=1 in RUN SHALL cause DONE in the next cycle.
REQ-028 In that case, no further pulse SHALL occur, done[owner]=1, and the RR pointer SHALL advance normally.
REQ-029 With BURST_SCHED_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE; abort in the same cycle as the final pulse SHALL still emit that pulse.
REQ-030 Without BURST_SCHED_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-031 Package burst_sched_pkg SHALL hold the FSM state typedef and the default CNT_NUM/CNT_GAP constants.
REQ-032 Sub-module burst_engine SHALL contain the gap/pulse counters: inputs start and stop, outputs pulse and last.
REQ-033 burst_scheduler SHALL contain the FSM, the arbiter and the re-arm flags.

Verification
REQ-034 CNT_NUM=3, CNT_GAP=4; req=0010 → gnt=0010 and busy at T, pulse at T+3, T+7 and T+11, done[1] at T+12.
REQ-035 req=0101 right after reset → requester 0 served first, then requester 2; with req[0] held high, requester 0 SHALL NOT be re-granted until it drops req.
REQ-036 All four requesters re-request after each done → grant order 0,1,2,3,0.
REQ-037 rst pulse after the 2nd pulse → all outputs 0, no done strobe; after release, req=0001 is granted normally.
REQ-038 BURST_SCHED_ABORT_EN, CNT_GAP=4; abort at T+5 → DONE at T+6, pulses only at T+3.
REQ-039 req[3] dropped at T+2 → burst still completes all CNT_NUM pulses, and done[3] is asserted.

Source files
------------

// File: rtl/burst_sched_pkg.sv
// Shared FSM state type, default burst timing and width helper for the burst scheduler.
package burst_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } burst_state_e;

  localparam int DEF_CNT_NUM = 32'sd15;
  localparam int DEF_CNT_GAP = 32'sd30;

  // Index width that stays legal when only one requester exists.
  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/burst_engine.sv
// Gap/pulse counters for one burst: pulse every CNT_GAP cycles, CNT_NUM times.
// 'last' rises together with the final pulse; 'stop' cancels without a further pulse.
module burst_engine
  import burst_sched_pkg::*;
#(
  parameter int CNT_NUM = DEF_CNT_NUM,
  parameter int CNT_GAP = DEF_CNT_GAP
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic pulse,
  output logic last
);

  localparam int GW = $clog2(CNT_GAP);
  localparam int NW = $clog2(CNT_NUM + 1);

  localparam logic [GW-1:0] GAP_LAST = GW'(CNT_GAP - 1);
  localparam logic [GW-1:0] GAP_PRE  = GW'(CNT_GAP - 2);
  localparam logic [NW-1:0] NUM_PRE  = NW'(CNT_NUM - 1);

  logic          run_r;
  logic [GW-1:0] gap_cnt_r;
  logic [NW-1:0] pulse_cnt_r;
  logic          pulse_r;
  logic          last_r;
  logic          gap_pre_s;
  logic          gap_wrap_s;

  // The pulse register is loaded one count early so it lines up with count == CNT_GAP-1.
  assign gap_pre_s  = (gap_cnt_r == GAP_PRE);
  assign gap_wrap_s = (gap_cnt_r == GAP_LAST);

  // Counter and registered pulse/last update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_r       <= 1'b0;
      gap_cnt_r   <= {GW{1'b0}};
      pulse_cnt_r <= {NW{1'b0}};
      pulse_r     <= 1'b0;
      last_r      <= 1'b0;
    end else if (start || stop || last_r) begin
      run_r       <= start && !stop;
      gap_cnt_r   <= {GW{1'b0}};
      pulse_cnt_r <= {NW{1'b0}};
      pulse_r     <= 1'b0;
      last_r      <= 1'b0;
    end else if (run_r) begin
      gap_cnt_r   <= gap_wrap_s ? {GW{1'b0}} : gap_cnt_r + 1'b1;
      pulse_cnt_r <= gap_pre_s ? pulse_cnt_r + 1'b1 : pulse_cnt_r;
      pulse_r     <= gap_pre_s;
      last_r      <= gap_pre_s && (pulse_cnt_r == NUM_PRE);
    end else begin
      run_r       <= run_r;
      gap_cnt_r   <= gap_cnt_r;
      pulse_cnt_r <= pulse_cnt_r;
      pulse_r     <= pulse_r;
      last_r      <= last_r;
    end
  end

  assign pulse = pulse_r;
  assign last  = last_r;

endmodule

// File: rtl/burst_scheduler.sv
// Round-robin burst scheduler: grants one requester a burst of CNT_NUM pulses.
// Optional abort input enabled by defining BURST_SCHED_ABORT_EN.
module burst_scheduler
  import burst_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_NUM = DEF_CNT_NUM,
  parameter int CNT_GAP = DEF_CNT_GAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               pulse,
  output logic [NUM_REQ-1:0] done
`ifdef BURST_SCHED_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam int PW = idx_width(NUM_REQ);

  burst_state_e       state_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [NUM_REQ-1:0] armed_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] done_r;
  logic               busy_r;

  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] win_oh_s;
  logic [NUM_REQ-1:0] clear_s;
  logic [PW-1:0]      win_idx_s;
  logic [PW-1:0]      next_ptr_s;
  logic [PW-1:0]      cand_s;
  logic               win_found_s;
  logic               start_s;
  logic               stop_s;
  logic               last_s;
  logic               finish_s;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [PW-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = {NUM_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign elig_s = req & armed_r;

  // Round-robin search starting at the requester after the last grant.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {PW{1'b0}};
    cand_s      = {PW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = PW'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!win_found_s && elig_s[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_idx_s   = win_idx_s;
      end
    end
  end

  assign win_oh_s   = idx_to_onehot(win_idx_s);
  assign next_ptr_s = (win_idx_s == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : win_idx_s + 1'b1;
  assign start_s    = (state_r == ST_IDLE) && win_found_s;

`ifdef BURST_SCHED_ABORT_EN
  assign stop_s = abort && (state_r == ST_RUN);
`else
  assign stop_s = 1'b0;
`endif

  assign finish_s = (state_r == ST_RUN) && (last_s || stop_s);
  assign clear_s  = finish_s ? gnt_r : {NUM_REQ{1'b0}};

  burst_engine #(
    .CNT_NUM (CNT_NUM),
    .CNT_GAP (CNT_GAP)
  ) u_engine (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .stop  (stop_s),
    .pulse (pulse),
    .last  (last_s)
  );

  // Scheduler FSM with registered grant, busy and done strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      gnt_r    <= {NUM_REQ{1'b0}};
      done_r   <= {NUM_REQ{1'b0}};
      busy_r   <= 1'b0;
      rr_ptr_r <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= {NUM_REQ{1'b0}};
          if (start_s) begin
            state_r  <= ST_RUN;
            gnt_r    <= win_oh_s;
            busy_r   <= 1'b1;
            rr_ptr_r <= next_ptr_s;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (finish_s) begin
            state_r <= ST_DONE;
            gnt_r   <= {NUM_REQ{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= gnt_r;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= {NUM_REQ{1'b0}};
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= {NUM_REQ{1'b0}};
          done_r  <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Re-arm flags: cleared at burst completion, set once the requester drops req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_r <= {NUM_REQ{1'b1}};
    end else begin
      armed_r <= (armed_r | ~req) & ~clear_s;
    end
  end

  assign gnt  = gnt_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_burst_scheduler.sv
// Directed bench for burst_scheduler (NUM_REQ=4, CNT_NUM=3, CNT_GAP=4); abort case needs BURST_SCHED_ABORT_EN.
module tb_burst_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       busy;
  logic       pulse;
  logic [3:0] done;
`ifdef BURST_SCHED_ABORT_EN
  logic       abort;
`endif

  int tests_run = 0;
  int failed    = 0;

  burst_scheduler #(
    .NUM_REQ (4),
    .CNT_NUM (3),
    .CNT_GAP (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .busy  (busy),
    .pulse (pulse),
    .done  (done)
`ifdef BURST_SCHED_ABORT_EN
    ,
    .abort (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [3:0] req_v;
    logic [3:0] exp_gnt;
    logic [3:0] drop_t2;
    logic       rearm;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_v;
    logic       busy_seen;
    logic       gnt_bad;
    logic       got_done;
    int         npulse;
    int         cyc;

    // req-pattern records: {reset first, req, expected grant, drop mask at T+2, re-arm after done}
    vec[0]  = '{1'b1, 4'b0101, 4'b0001, 4'b0000, 1'b0};
    vec[1]  = '{1'b0, 4'b0101, 4'b0100, 4'b0000, 1'b0};
    vec[2]  = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    vec[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vec[4]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0};
    vec[5]  = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1};
    vec[6]  = '{1'b0, 4'b1111, 4'b0010, 4'b0000, 1'b1};
    vec[7]  = '{1'b0, 4'b1111, 4'b0100, 4'b0000, 1'b1};
    vec[8]  = '{1'b0, 4'b1111, 4'b1000, 4'b0000, 1'b1};
    vec[9]  = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1};
    vec[10] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0};

    rst = 1'b1;
    req = 4'b0000;
`ifdef BURST_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_state", {22'd0, busy, gnt, pulse, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {22'd0, busy, gnt, pulse, done}, 32'd0);

    // Cycle-exact burst for requester 1, req held afterwards (must not re-grant).
    req = 4'b0010;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k < 12)       exp_v = {1'b1, 4'b0010, (k == 3 || k == 7 || k == 11), 4'b0000};
      else if (k == 12) exp_v = {1'b0, 4'b0000, 1'b0, 4'b0010};
      else              exp_v = 10'd0;
      check($sformatf("burst_r1_T+%0d", k), {22'd0, busy, gnt, pulse, done}, {22'd0, exp_v});
    end
    req = 4'b0000;

    // Table of arbitration / re-arm cases.
    for (int i = 0; i < NV; i++) begin
      if (vec[i].do_rst) do_reset();
      req = vec[i].req_v;
      if (vec[i].exp_gnt == 4'b0000) begin
        busy_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (busy) busy_seen = 1'b1;
        end
        check($sformatf("vec%0d_no_grant", i), {31'd0, busy_seen}, 32'd0);
      end else begin
        @(negedge clk);
        check($sformatf("vec%0d_grant", i), {27'd0, busy, gnt}, {27'd0, 1'b1, vec[i].exp_gnt});
        npulse   = 0;
        cyc      = 0;
        gnt_bad  = 1'b0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
          if (pulse) npulse++;
          if (busy !== 1'b1 || gnt !== vec[i].exp_gnt) gnt_bad = 1'b1;
          if (cyc == 2) req = req & ~vec[i].drop_t2;
          @(negedge clk);
          cyc++;
          if (done != 4'b0000) got_done = 1'b1;
        end
        check($sformatf("vec%0d_burst_len", i), cyc, 32'd12);
        check($sformatf("vec%0d_pulses", i), npulse, 32'd3);
        check($sformatf("vec%0d_held", i), {31'd0, gnt_bad}, 32'd0);
        check($sformatf("vec%0d_done", i), {27'd0, busy, done}, {28'd0, vec[i].exp_gnt});
        if (vec[i].rearm) req = vec[i].req_v & ~vec[i].exp_gnt;
        @(negedge clk);
      end
    end

    // Reset in the middle of a burst, right after the second pulse.
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    check("mid_rst_grant", {27'd0, busy, gnt}, {27'd0, 5'b10001});
    npulse = 0;
    cyc    = 0;
    while (npulse < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pulse) npulse++;
    end
    check("mid_rst_second_pulse_cycle", cyc, 32'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {22'd0, busy, gnt, pulse, done}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mid_rst_no_done", {22'd0, busy, gnt, pulse, done}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", {27'd0, busy, gnt}, {27'd0, 5'b10001});

`ifdef BURST_SCHED_ABORT_EN
    // Abort at T+5: only the T+3 pulse, DONE at T+6; abort in IDLE is ignored.
    do_reset();
    req   = 4'b0100;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_grant", {27'd0, busy, gnt}, {27'd0, 5'b10100});
    npulse = 0;
    for (int k = 0; k < 9; k++) begin
      if (pulse) npulse++;
      if (k == 3) check("abort_pulse_T+3", {31'd0, pulse}, 32'd1);
      if (k == 5) abort = 1'b1;
      if (k == 6) begin
        abort = 1'b0;
        check("abort_done_T+6", {27'd0, busy, done}, {27'd0, 5'b00100});
      end
      if (k == 7) check("abort_done_once", {28'd0, done}, 32'd0);
      @(negedge clk);
    end
    check("abort_pulse_count", npulse, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
